framebuffer_writer: RTL and testbench

//  Write-side master for the shared framebuffer that the VGA display block scans out.

---
 rtl/buffer_config_pkg.sv | 18 +
 rtl/fb_cmd_pkg.sv | 40 ++++
 rtl/fb_rect_clip.sv | 38 +++
 rtl/framebuffer_writer.sv | 160 ++++++++++++++++
 tb/tb_framebuffer_writer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/buffer_config_pkg.sv
// Framebuffer geometry shared by the display scan-out and the write-side master.
package buffer_config_pkg;

  typedef struct packed {
    int unsigned width;
    int unsigned height;
    int unsigned addr_width;
    int unsigned data_width;
  } buffer_config_t;

  localparam buffer_config_t BUFFER_160x120x12 = '{
    width:      160,
    height:     120,
    addr_width: 15,
    data_width: 12
  };

endpackage

// File: rtl/fb_cmd_pkg.sv
// Command, opcode and FSM types for the framebuffer writer, plus a constant-multiply helper.
package fb_cmd_pkg;
  import buffer_config_pkg::*;

  localparam int FB_XW = $clog2(BUFFER_160x120x12.width) + 1;
  localparam int FB_YW = $clog2(BUFFER_160x120x12.height) + 1;
  localparam int FB_DW = BUFFER_160x120x12.data_width;

  typedef enum logic {
    FB_FILL_RECT = 1'b0,
    FB_CLEAR     = 1'b1
  } fb_cmd_op_t;

  typedef struct packed {
    fb_cmd_op_t       op;
    logic [FB_XW-1:0] x;
    logic [FB_YW-1:0] y;
    logic [FB_XW-1:0] w;
    logic [FB_YW-1:0] h;
    logic [FB_DW-1:0] color;
  } fb_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } fb_writer_state_t;

  // k is always an elaboration-time constant, so this folds into a few shifted adds.
  function automatic logic [31:0] mulConst(input logic [31:0] a, input int unsigned k);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      if (k[i]) acc = acc + (a << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/fb_rect_clip.sv
// Purely combinational clip of a rectangle against the framebuffer bounds.
module fb_rect_clip
  import buffer_config_pkg::*;
#(
  parameter buffer_config_t BUFFER_CONFIG = BUFFER_160x120x12
) (
  input  logic [$clog2(BUFFER_CONFIG.width):0]  i_x,
  input  logic [$clog2(BUFFER_CONFIG.height):0] i_y,
  input  logic [$clog2(BUFFER_CONFIG.width):0]  i_w,
  input  logic [$clog2(BUFFER_CONFIG.height):0] i_h,
  output logic [$clog2(BUFFER_CONFIG.width):0]  o_xStart,
  output logic [$clog2(BUFFER_CONFIG.height):0] o_yStart,
  output logic [$clog2(BUFFER_CONFIG.width):0]  o_xEnd,
  output logic [$clog2(BUFFER_CONFIG.height):0] o_yEnd,
  output logic                                  o_empty
);

  localparam int XW = $clog2(BUFFER_CONFIG.width) + 1;
  localparam int YW = $clog2(BUFFER_CONFIG.height) + 1;
  localparam logic [XW:0] WIDTH_EXT  = (XW + 1)'(BUFFER_CONFIG.width);
  localparam logic [YW:0] HEIGHT_EXT = (YW + 1)'(BUFFER_CONFIG.height);

  logic [XW:0] w_xSum;
  logic [YW:0] w_ySum;

  // The extra sum bit keeps x+w from wrapping before it is compared to the edge.
  always_comb begin
    w_xSum   = {1'b0, i_x} + {1'b0, i_w};
    w_ySum   = {1'b0, i_y} + {1'b0, i_h};
    o_xStart = i_x;
    o_yStart = i_y;
    o_xEnd   = (w_xSum > WIDTH_EXT)  ? WIDTH_EXT[XW-1:0]  : w_xSum[XW-1:0];
    o_yEnd   = (w_ySum > HEIGHT_EXT) ? HEIGHT_EXT[YW-1:0] : w_ySum[YW-1:0];
    o_empty  = (i_w == '0) || (i_h == '0) ||
               ({1'b0, i_x} >= WIDTH_EXT) || ({1'b0, i_y} >= HEIGHT_EXT);
  end

endmodule

// File: rtl/framebuffer_writer.sv
// Write-side framebuffer master: accepts FILL_RECT/CLEAR commands and streams one clipped
// pixel per clock into the BRAM write port in raster order.
module framebuffer_writer
  import buffer_config_pkg::*;
  import fb_cmd_pkg::*;
#(
  parameter buffer_config_t BUFFER_CONFIG = BUFFER_160x120x12
) (
  input  logic                                   clk_system,
  input  logic                                   rstn_system,
  input  logic                                   cmd_valid,
  output logic                                   cmd_ready,
  input  fb_cmd_op_t                             cmd_op,
  input  logic [$clog2(BUFFER_CONFIG.width):0]   cmd_x,
  input  logic [$clog2(BUFFER_CONFIG.height):0]  cmd_y,
  input  logic [$clog2(BUFFER_CONFIG.width):0]   cmd_w,
  input  logic [$clog2(BUFFER_CONFIG.height):0]  cmd_h,
  input  logic [BUFFER_CONFIG.data_width-1:0]    cmd_color,
  output logic                                   write_en,
  output logic [BUFFER_CONFIG.addr_width-1:0]    write_addr,
  output logic [BUFFER_CONFIG.data_width-1:0]    write_data,
  output logic                                   busy,
  output logic                                   done
);

  localparam int XW = $clog2(BUFFER_CONFIG.width) + 1;
  localparam int YW = $clog2(BUFFER_CONFIG.height) + 1;
  localparam int AW = BUFFER_CONFIG.addr_width;
  localparam int DW = BUFFER_CONFIG.data_width;
  localparam logic [XW-1:0] FULL_W   = XW'(BUFFER_CONFIG.width);
  localparam logic [YW-1:0] FULL_H   = YW'(BUFFER_CONFIG.height);
  localparam logic [AW-1:0] ROW_STEP = AW'(BUFFER_CONFIG.width);

  fb_writer_state_t r_state;
  fb_cmd_op_t       r_op;
  logic [XW-1:0]    r_cmdX, r_cmdW, r_x, r_xStart, r_xEnd;
  logic [YW-1:0]    r_cmdY, r_cmdH, r_y, r_yEnd;
  logic [AW-1:0]    r_rowBase, r_writeAddr;
  logic [DW-1:0]    r_writeData;
  logic             r_writeEn, r_busy, r_done, r_cmdReady;

  logic [XW-1:0]    w_clipX, w_clipW, w_xStart, w_xEnd, w_xNext;
  logic [YW-1:0]    w_clipY, w_clipH, w_yStart, w_yEnd, w_yNext;
  logic [AW-1:0]    w_firstRowBase, w_nextRowBase;
  logic             w_empty, w_lastCol, w_lastRow;

  // CLEAR reuses the rectangle path as a full-buffer fill.
  always_comb begin
    w_clipX        = (r_op == FB_CLEAR) ? '0     : r_cmdX;
    w_clipY        = (r_op == FB_CLEAR) ? '0     : r_cmdY;
    w_clipW        = (r_op == FB_CLEAR) ? FULL_W : r_cmdW;
    w_clipH        = (r_op == FB_CLEAR) ? FULL_H : r_cmdH;
    w_firstRowBase = AW'(mulConst(32'(w_yStart), BUFFER_CONFIG.width));
    w_xNext        = r_x + 1'b1;
    w_yNext        = r_y + 1'b1;
    w_lastCol      = (w_xNext == r_xEnd);
    w_lastRow      = (w_yNext == r_yEnd);
    w_nextRowBase  = r_rowBase + ROW_STEP;
  end

  fb_rect_clip #(
    .BUFFER_CONFIG(BUFFER_CONFIG)
  ) u_rectClip (
    .i_x     (w_clipX),
    .i_y     (w_clipY),
    .i_w     (w_clipW),
    .i_h     (w_clipH),
    .o_xStart(w_xStart),
    .o_yStart(w_yStart),
    .o_xEnd  (w_xEnd),
    .o_yEnd  (w_yEnd),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk_system or negedge rstn_system) begin
    if (!rstn_system) begin
      r_state     <= IDLE;
      r_op        <= FB_FILL_RECT;
      r_cmdX      <= '0;
      r_cmdY      <= '0;
      r_cmdW      <= '0;
      r_cmdH      <= '0;
      r_x         <= '0;
      r_xStart    <= '0;
      r_xEnd      <= '0;
      r_y         <= '0;
      r_yEnd      <= '0;
      r_rowBase   <= '0;
      r_writeAddr <= '0;
      r_writeData <= '0;
      r_writeEn   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cmdReady  <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid && r_cmdReady) begin
            r_op        <= cmd_op;
            r_cmdX      <= cmd_x;
            r_cmdY      <= cmd_y;
            r_cmdW      <= cmd_w;
            r_cmdH      <= cmd_h;
            r_writeData <= cmd_color;
            r_cmdReady  <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= SETUP;
          end
        end
        SETUP: begin
          if (w_empty) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_x         <= w_xStart;
            r_xStart    <= w_xStart;
            r_xEnd      <= w_xEnd;
            r_y         <= w_yStart;
            r_yEnd      <= w_yEnd;
            r_rowBase   <= w_firstRowBase;
            r_writeAddr <= w_firstRowBase + AW'(w_xStart);
            r_writeEn   <= 1'b1;
            r_state     <= FILL;
          end
        end
        FILL: begin
          // write_addr always holds row_base + x for the pixel currently on the port.
          if (w_lastCol && w_lastRow) begin
            r_writeEn <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= DONE;
          end else if (w_lastCol) begin
            r_x         <= r_xStart;
            r_y         <= w_yNext;
            r_rowBase   <= w_nextRowBase;
            r_writeAddr <= w_nextRowBase + AW'(r_xStart);
          end else begin
            r_x         <= w_xNext;
            r_writeAddr <= r_writeAddr + 1'b1;
          end
        end
        DONE: begin
          r_busy     <= 1'b0;
          r_cmdReady <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = r_cmdReady;
  assign write_en   = r_writeEn;
  assign write_addr = r_writeAddr;
  assign write_data = r_writeData;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Scoreboard bench for framebuffer_writer: a pixel-list model feeds a queue that a
// negedge monitor drains whenever the DUT writes or signals done.
module tb_framebuffer_writer;
  import buffer_config_pkg::*;
  import fb_cmd_pkg::*;

  localparam int FBW = 160;
  localparam int FBH = 120;
  localparam int WAIT_LIMIT = 25000;

  typedef struct {
    bit isDone;
    bit nonEmpty;
    int addr;
    int data;
  } fbExp_t;

  logic                  clk_system = 1'b0;
  logic                  rstn_system = 1'b0;
  logic                  cmd_valid = 1'b0;
  logic                  cmd_ready;
  fb_cmd_op_t            cmd_op = FB_FILL_RECT;
  logic [FB_XW-1:0]      cmd_x = '0;
  logic [FB_YW-1:0]      cmd_y = '0;
  logic [FB_XW-1:0]      cmd_w = '0;
  logic [FB_YW-1:0]      cmd_h = '0;
  logic [FB_DW-1:0]      cmd_color = '0;
  logic                  write_en;
  logic [14:0]           write_addr;
  logic [FB_DW-1:0]      write_data;
  logic                  busy;
  logic                  done;

  int checks = 0;
  int errors = 0;
  fbExp_t expQ[$];
  fbExp_t monE;
  bit prevWasWrite = 1'b0;

  framebuffer_writer #(.BUFFER_CONFIG(BUFFER_160x120x12)) dut (
    .clk_system (clk_system),
    .rstn_system(rstn_system),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .cmd_w      (cmd_w),
    .cmd_h      (cmd_h),
    .cmd_color  (cmd_color),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk_system = ~clk_system;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: enumerate the clipped pixels in raster order, then a done marker.
  function automatic void pushExpected(input bit isClear, input int x, input int y,
                                       input int w, input int h, input int color);
    int xe, ye;
    bit empty;
    fbExp_t e;
    if (isClear) begin
      x = 0; y = 0; w = FBW; h = FBH;
    end
    xe = (x + w < FBW) ? x + w : FBW;
    ye = (y + h < FBH) ? y + h : FBH;
    empty = (w == 0) || (h == 0) || (x >= FBW) || (y >= FBH);
    if (!empty) begin
      for (int yy = y; yy < ye; yy++) begin
        for (int xx = x; xx < xe; xx++) begin
          e = '{isDone: 1'b0, nonEmpty: 1'b1, addr: yy * FBW + xx, data: color};
          expQ.push_back(e);
        end
      end
    end
    e = '{isDone: 1'b1, nonEmpty: !empty, addr: 0, data: 0};
    expQ.push_back(e);
  endfunction

  task automatic applyStimulus(input fb_cmd_t c);
    int n = 0;
    @(negedge clk_system);
    cmd_valid = 1'b1;
    cmd_op    = c.op;
    cmd_x     = c.x;
    cmd_y     = c.y;
    cmd_w     = c.w;
    cmd_h     = c.h;
    cmd_color = c.color;
    while (!cmd_ready && n < WAIT_LIMIT) begin
      @(negedge clk_system);
      n++;
    end
    if (n >= WAIT_LIMIT) begin
      checks++;
      errors++;
      $display("[TB] FAIL acceptTimeout: cmd_ready stayed %0d expected 1", cmd_ready);
    end else begin
      @(posedge clk_system);
      pushExpected(c.op == FB_CLEAR, int'(c.x), int'(c.y), int'(c.w), int'(c.h), int'(c.color));
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    @(negedge clk_system);
    while ((expQ.size() != 0 || !cmd_ready) && n < WAIT_LIMIT) begin
      @(negedge clk_system);
      n++;
    end
    checkOutput(name, (n < WAIT_LIMIT) ? 1 : 0, 1);
  endtask

  function automatic fb_cmd_t mkCmd(input fb_cmd_op_t op, input int x, input int y,
                                    input int w, input int h, input int color);
    fb_cmd_t c;
    c.op    = op;
    c.x     = FB_XW'(x);
    c.y     = FB_YW'(y);
    c.w     = FB_XW'(w);
    c.h     = FB_YW'(h);
    c.color = FB_DW'(color);
    return c;
  endfunction

  // Monitor: every write and every done pulse consumes the head of the scoreboard.
  always @(negedge clk_system) begin
    if (!rstn_system) begin
      prevWasWrite = 1'b0;
    end else begin
      if (write_en) begin
        if (expQ.size() == 0 || expQ[0].isDone) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedWrite: addr %0d data %0h, none required", write_addr, write_data);
        end else begin
          monE = expQ.pop_front();
          checkOutput("writeAddr", int'(write_addr), monE.addr);
          checkOutput("writeData", int'(write_data), monE.data);
        end
      end
      if (done) begin
        if (expQ.size() == 0 || !expQ[0].isDone) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedDone: done=1 with %0d pixels still required", expQ.size());
        end else begin
          monE = expQ.pop_front();
          if (monE.nonEmpty) checkOutput("doneAfterLastWrite", int'(prevWasWrite), 1);
          checkOutput("writeEnWithDone", int'(write_en), 0);
        end
      end
      if (!write_en && !done && prevWasWrite) begin
        checks++;
        errors++;
        $display("[TB] FAIL writeGap: write_en=0 done=0 after a write, required write or done");
      end
      prevWasWrite = write_en;
    end
  end

  initial begin
    fb_cmd_t c;
    int rx, ry, rw, rh;

    // Scenario 1: reset values.
    repeat (3) @(negedge clk_system);
    #2 rstn_system = 1'b1;
    @(negedge clk_system);
    checkOutput("resetCmdReady", int'(cmd_ready), 1);
    checkOutput("resetWriteEn", int'(write_en), 0);
    checkOutput("resetBusy", int'(busy), 0);
    checkOutput("resetDone", int'(done), 0);
    checkOutput("resetAddr", int'(write_addr), 0);
    checkOutput("resetData", int'(write_data), 0);

    // Scenario 2: exact cycle timing of a small fill.
    applyStimulus(mkCmd(FB_FILL_RECT, 2, 3, 3, 2, 12'hF00));
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk_system);
      checkOutput($sformatf("s2WriteEnT+%0d", k), int'(write_en), (k >= 2 && k <= 7) ? 1 : 0);
      checkOutput($sformatf("s2DoneT+%0d", k), int'(done), (k == 8) ? 1 : 0);
      checkOutput($sformatf("s2ReadyT+%0d", k), int'(cmd_ready), (k == 9) ? 1 : 0);
      checkOutput($sformatf("s2BusyT+%0d", k), int'(busy), (k <= 8) ? 1 : 0);
    end
    waitIdle("s2Idle");

    // Scenario 3: bottom-right corner clip.
    applyStimulus(mkCmd(FB_FILL_RECT, 158, 119, 10, 10, 12'h0A5));
    waitIdle("s3Idle");

    // Scenario 4: empty rectangles report done at T+2 without writing.
    for (int s = 0; s < 2; s++) begin
      if (s == 0) applyStimulus(mkCmd(FB_FILL_RECT, 5, 5, 0, 4, 12'h123));
      else        applyStimulus(mkCmd(FB_FILL_RECT, 160, 5, 4, 4, 12'h321));
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk_system);
        checkOutput($sformatf("s4DoneT+%0d", k), int'(done), (k == 2) ? 1 : 0);
        checkOutput($sformatf("s4WriteEnT+%0d", k), int'(write_en), 0);
      end
      waitIdle("s4Idle");
    end

    // Scenario 5: full clear.
    applyStimulus(mkCmd(FB_CLEAR, 7, 9, 3, 3, 12'h000));
    waitIdle("s5Idle");

    // Back-to-back randomized fills, including off-edge and zero-size cases.
    for (int i = 0; i < 40; i++) begin
      rx = $urandom_range(170, 0);
      ry = $urandom_range(130, 0);
      rw = $urandom_range(20, 0);
      rh = $urandom_range(12, 0);
      c = mkCmd(FB_FILL_RECT, rx, ry, rw, rh, $urandom_range(4095, 0));
      applyStimulus(c);
    end
    waitIdle("randomIdle");

    // Scenario 6: reset during the third write aborts the fill.
    applyStimulus(mkCmd(FB_FILL_RECT, 2, 3, 3, 2, 12'hF00));
    repeat (4) @(negedge clk_system);
    checkOutput("s6ThirdWrite", int'(write_en), 1);
    #2 rstn_system = 1'b0;
    #1;
    checkOutput("s6WriteEnInReset", int'(write_en), 0);
    checkOutput("s6ReadyInReset", int'(cmd_ready), 1);
    checkOutput("s6BusyInReset", int'(busy), 0);
    expQ.delete();
    repeat (2) @(negedge clk_system);
    #2 rstn_system = 1'b1;
    applyStimulus(mkCmd(FB_FILL_RECT, 0, 0, 1, 1, 12'h7E7));
    waitIdle("s6Idle");

    repeat (3) @(negedge clk_system);
    checkOutput("finalQueueEmpty", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
